uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 131 +++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Samples a 2-flop synchronized line at mid-bit and emits
// one-cycle rx_valid / frame_err pulses per frame.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk_50m,
  input  logic       rst_n,
  input  logic       uart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  logic       meta_q, rxd_s_q, rxd_prev_q, fall_q;
  logic [2:0] sync_vld_q;

  // sync_vld_q marks when meta/sync/prev all hold real line samples, so a line
  // already low when reset releases never looks like a falling edge.
  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      meta_q     <= 1'b1;
      rxd_s_q    <= 1'b1;
      rxd_prev_q <= 1'b1;
      sync_vld_q <= '0;
      fall_q     <= 1'b0;
    end else begin
      meta_q     <= uart_rxd;
      rxd_s_q    <= meta_q;
      rxd_prev_q <= rxd_s_q;
      sync_vld_q <= {sync_vld_q[1:0], 1'b1};
      fall_q     <= sync_vld_q[2] & rxd_prev_q & ~rxd_s_q;
    end
  end

  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fall_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rxd_s_q) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rxd_s_q;
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rxd_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign rx_busy   = (state_q != IDLE);

endmodule
